ps2_send: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. LED set, reset, typematic)
//  to a keyboard/mouse over the open-drain PS/2 clock/data pair. Shares the pins with the
//  PS/2 receiver; while busy=1 the receiver's result must be ignored. Drives lines low only

---
 rtl/ps2_send.sv | 158 +++++++++++++++
 tb/tb_ps2_send.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_send.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, then shifts one
// byte out on device clock falling edges and checks the device ACK. Pins are open-drain via *_oe.
module ps2_send #(
    parameter int FREQ          = 12500,
    parameter int INHIBIT       = FREQ / 10,
    parameter int START_TIMEOUT = FREQ * 15,
    parameter int BIT_TIMEOUT   = FREQ * 2,
    parameter int TIMER_W       = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] din,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_XMIT,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(INHIBIT - 1);
    localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BIT_LAST   = TIMER_W'(BIT_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

    state_t             state;
    logic [4:0]         clk_r;
    logic [4:0]         data_r;
    logic [9:0]         frame;
    logic [3:0]         bitcnt;
    logic [TIMER_W-1:0] timer;

    logic               fall;
    logic               rise;
    logic               lines_idle;
    logic               first_seen;
    logic               timer_clr;
    logic [TIMER_W-1:0] limit;
    logic               timeout;

    function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] t);
        return (t == TIMER_MAX) ? t : t + 1'b1;
    endfunction

    assign fall       = (clk_r[4:1] == 4'b1100);
    assign rise       = (clk_r[4:1] == 4'b0011);
    assign lines_idle = (&clk_r[4:1]) & (&data_r[4:1]);

    // The rise caused by the host releasing the clock is not a device edge, so it must not
    // restart the start timeout.
    assign first_seen = (state != ST_XMIT) || (bitcnt != 4'd0);
    assign timer_clr  = fall || (rise && first_seen);
    assign limit      = (state == ST_XMIT && bitcnt == 4'd0) ? START_LAST : BIT_LAST;
    assign timeout    = (timer == limit) && !timer_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            clk_r       <= 5'b11111;
            data_r      <= 5'b11111;
            frame       <= '0;
            bitcnt      <= '0;
            timer       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            error       <= 1'b0;
        end else begin
            clk_r  <= {clk_r[3:0], ps2_clk};
            data_r <= {data_r[3:0], ps2_data};
            done   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    // A send coinciding with the done pulse is dropped.
                    if (send && !done) begin
                        frame      <= {1'b1, ~^din, din};
                        ack_err    <= 1'b0;
                        error      <= 1'b0;
                        timer      <= '0;
                        bitcnt     <= '0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (timer == INH_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= ST_REQ;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end

                ST_REQ: begin
                    ps2_clk_oe <= 1'b0;
                    timer      <= '0;
                    state      <= ST_XMIT;
                end

                ST_XMIT, ST_ACK, ST_WAIT_IDLE: begin
                    if (timeout) begin
                        error       <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer_clr ? '0 : sat_inc(timer);
                        if (state == ST_XMIT) begin
                            if (fall) begin
                                ps2_data_oe <= ~frame[0];
                                frame       <= {1'b0, frame[9:1]};
                                bitcnt      <= bitcnt + 4'd1;
                                if (bitcnt == 4'd9)
                                    state <= ST_ACK;
                            end
                        end else if (state == ST_ACK) begin
                            ps2_data_oe <= 1'b0;
                            if (fall) begin
                                ack_err <= data_r[4];
                                state   <= ST_WAIT_IDLE;
                            end
                        end else begin
                            if (lines_idle) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_send.sv
// Directed bench for ps2_send: a behavioural PS/2 device clocks frames, samples data on
// rising edges and optionally ACKs; each task checks one scenario against hand-derived values.
module tb_ps2_send;

    localparam int INHIBIT       = 20;
    localparam int START_TIMEOUT = 400;
    localparam int BIT_TIMEOUT   = 120;
    localparam int TIMER_W       = 10;
    localparam int H             = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       send = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_clk_lo = 1'b0;
    logic       dev_data_lo = 1'b0;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       error;

    int compared = 0;
    int mismatched = 0;

    assign ps2_clk  = !(ps2_clk_oe || dev_clk_lo);
    assign ps2_data = !(ps2_data_oe || dev_data_lo);

    ps2_send #(
        .FREQ(12500),
        .INHIBIT(INHIBIT),
        .START_TIMEOUT(START_TIMEOUT),
        .BIT_TIMEOUT(BIT_TIMEOUT),
        .TIMER_W(TIMER_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .send(send),
        .din(din),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy),
        .done(done),
        .ack_err(ack_err),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        din  = d;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Device model; bits = {stop, parity, d7..d0, start}. inject>0 pulses send (din=3C)
    // during that falling edge.
    task automatic device_frame(input int nfalls, input bit do_ack, input int inject,
                                output logic [10:0] bits);
        int guard;
        bits  = '0;
        guard = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        compared++;
        if (guard >= 2000) begin
            mismatched++;
            $display("FAIL rts_wait: clk_oe=%b data_oe=%b, required 0/1", ps2_clk_oe, ps2_data_oe);
        end
        repeat (H) @(negedge clk);
        bits[0] = ps2_data;
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk_lo = 1'b1;
            if (k == inject) begin
                din  = 8'h3C;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
                repeat (H - 1) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            dev_clk_lo = 1'b0;
            bits[k]    = ps2_data;
            repeat (H) @(negedge clk);
        end
        if (nfalls == 10) begin
            dev_data_lo = do_ack;
            repeat (H / 2) @(negedge clk);
            dev_clk_lo = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_lo = 1'b0;
            repeat (3) @(negedge clk);
            dev_data_lo = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        compared++;
        if ({ps2_clk_oe, ps2_data_oe, busy, done, ack_err, error} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b, required 000000",
                     {ps2_clk_oe, ps2_data_oe, busy, done, ack_err, error});
        end
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_send_held: busy=%b, required 0", busy);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b0) begin
            mismatched++;
            $display("FAIL post_reset_idle: got %b, required 000", {ps2_clk_oe, ps2_data_oe, busy});
        end
    endtask

    task automatic test_send_ok;
        int cnt;
        bit seen;
        logic [10:0] bits;
        send_byte(8'hED);
        cnt = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        compared++;
        if (cnt != INHIBIT) begin
            mismatched++;
            $display("FAIL inhibit_len: %0d cycles, required %0d", cnt, INHIBIT);
        end
        compared++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin
            mismatched++;
            $display("FAIL req_state: oe=%b, required 11", {ps2_clk_oe, ps2_data_oe});
        end
        @(negedge clk);
        compared++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b011) begin
            mismatched++;
            $display("FAIL clk_release: oe/busy=%b, required 011", {ps2_clk_oe, ps2_data_oe, busy});
        end
        device_frame(10, 1'b1, 0, bits);
        compared++;
        if (bits !== 11'b11_1110_1101_0) begin
            mismatched++;
            $display("FAIL frame_ED: got %b, required %b", bits, 11'b11_1110_1101_0);
        end
        wait_done(seen);
        compared++;
        if (!seen || ack_err !== 1'b0 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL done_ED: done_seen=%0d ack_err=%b error=%b, required 1/0/0",
                     seen, ack_err, error);
        end
        @(negedge clk);
        compared++;
        if ({done, busy} !== 2'b00) begin
            mismatched++;
            $display("FAIL done_pulse_width: done/busy=%b, required 00", {done, busy});
        end
    endtask

    task automatic test_nack;
        bit seen;
        logic [10:0] bits;
        send_byte(8'hFF);
        device_frame(10, 1'b0, 0, bits);
        compared++;
        if (bits !== 11'b11_1111_1111_0) begin
            mismatched++;
            $display("FAIL frame_FF: got %b, required %b", bits, 11'b11_1111_1111_0);
        end
        wait_done(seen);
        compared++;
        if (!seen || ack_err !== 1'b1 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL nack_flags: done_seen=%0d ack_err=%b error=%b, required 1/1/0",
                     seen, ack_err, error);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (ack_err !== 1'b1) begin
            mismatched++;
            $display("FAIL nack_sticky: ack_err=%b, required 1", ack_err);
        end
        send_byte(8'h55);
        compared++;
        if ({ack_err, busy} !== 2'b01) begin
            mismatched++;
            $display("FAIL nack_clear: ack_err/busy=%b, required 01", {ack_err, busy});
        end
        device_frame(10, 1'b1, 0, bits);
        wait_done(seen);
        compared++;
        if (!seen || ack_err !== 1'b0) begin
            mismatched++;
            $display("FAIL resend_ok: done_seen=%0d ack_err=%b, required 1/0", seen, ack_err);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_start_timeout;
        int guard;
        int cnt;
        send_byte(8'h42);
        guard = 0;
        while (ps2_clk_oe !== 1'b0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        cnt = 0;
        while (error !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        compared++;
        if (cnt != START_TIMEOUT) begin
            mismatched++;
            $display("FAIL start_timeout_len: %0d cycles, required %0d", cnt, START_TIMEOUT);
        end
        compared++;
        if ({ps2_clk_oe, ps2_data_oe, done, busy, ack_err} !== 5'b00100) begin
            mismatched++;
            $display("FAIL start_timeout_state: oe/done/busy/ack_err=%b, required 00100",
                     {ps2_clk_oe, ps2_data_oe, done, busy, ack_err});
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bit_timeout;
        int cnt;
        logic [10:0] bits;
        send_byte(8'h0F);
        device_frame(4, 1'b1, 0, bits);
        cnt = 0;
        while (error !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        // Counted from H cycles after the last device rise; the rise takes 4 cycles to be seen.
        compared++;
        if (cnt != BIT_TIMEOUT + 4 - H) begin
            mismatched++;
            $display("FAIL bit_timeout_len: %0d cycles, required %0d", cnt, BIT_TIMEOUT + 4 - H);
        end
        compared++;
        if ({ps2_clk_oe, ps2_data_oe, done, busy, ack_err} !== 5'b00100) begin
            mismatched++;
            $display("FAIL bit_timeout_state: oe/done/busy/ack_err=%b, required 00100",
                     {ps2_clk_oe, ps2_data_oe, done, busy, ack_err});
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_send_ignored;
        bit seen;
        logic [10:0] bits;
        send_byte(8'hA5);
        device_frame(10, 1'b1, 3, bits);
        compared++;
        if (bits !== 11'b11_1010_0101_0) begin
            mismatched++;
            $display("FAIL frame_A5_ignore: got %b, required %b", bits, 11'b11_1010_0101_0);
        end
        wait_done(seen);
        compared++;
        if (!seen || {ack_err, error} !== 2'b00) begin
            mismatched++;
            $display("FAIL ignore_done: done_seen=%0d flags=%b, required 1/00", seen, {ack_err, error});
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit seen;
        logic [10:0] bits;
        send_byte(8'h21);
        device_frame(10, 1'b1, 0, bits);
        wait_done(seen);
        din  = 8'h77;
        send = 1'b1;
        @(negedge clk);
        compared++;
        if (!seen || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL send_on_done: done_seen=%0d busy=%b, required 1/0", seen, busy);
        end
        @(negedge clk);
        send = 1'b0;
        compared++;
        if ({busy, ps2_clk_oe} !== 2'b11) begin
            mismatched++;
            $display("FAIL send_after_done: busy/clk_oe=%b, required 11", {busy, ps2_clk_oe});
        end
        device_frame(10, 1'b1, 0, bits);
        compared++;
        if (bits !== 11'b11_0111_0111_0) begin
            mismatched++;
            $display("FAIL frame_77: got %b, required %b", bits, 11'b11_0111_0111_0);
        end
        wait_done(seen);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit seen;
        logic [10:0] bits;
        send_byte(8'h99);
        device_frame(3, 1'b1, 0, bits);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_busy: busy=%b, required 1", busy);
        end
        reset = 1'b0;
        #1;
        compared++;
        if ({ps2_clk_oe, ps2_data_oe, busy, done} !== 4'b0) begin
            mismatched++;
            $display("FAIL mid_reset: oe/busy/done=%b, required 0000",
                     {ps2_clk_oe, ps2_data_oe, busy, done});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h13);
        device_frame(10, 1'b1, 0, bits);
        compared++;
        if (bits !== 11'b10_0001_0011_0) begin
            mismatched++;
            $display("FAIL frame_13: got %b, required %b", bits, 11'b10_0001_0011_0);
        end
        wait_done(seen);
        compared++;
        if (!seen || {ack_err, error} !== 2'b00) begin
            mismatched++;
            $display("FAIL recover_done: done_seen=%0d flags=%b, required 1/00", seen, {ack_err, error});
        end
    endtask

    initial begin
        test_reset();
        test_send_ok();
        test_nack();
        test_start_timeout();
        test_bit_timeout();
        test_send_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
